lsu_data_master: RTL and testbench

- Load/store initiator that drives the unified memory's data port (address, write data, read strobe, write strobe, read data) on behalf of the pipeline's MEM stage.
- Converts byte, halfword and word requests into word-aligned memory accesses. Sub-word stores use read-modify-write.
- Extends load results to the requested size and signedness. Flags misaligned or out-of-region accesses without touching memory.
- Sits between the MEM-stage pipeline register and the memory's data port; the memory's instruction port is unaffected.

---
 rtl/lsu_data_master.sv | 197 +++++++++++++++++++
 tb/tb_lsu_data_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_master.sv
// lsu_data_master
// ---------------
// Load/store initiator sitting between the MEM-stage pipeline register and
// the data port of the unified memory. Byte, halfword and word requests are
// turned into word-aligned memory accesses. Sub-word stores use a
// read-modify-write of the containing word. Load results are extended to
// the requested size and signedness. Misaligned, reserved-size and
// out-of-region requests are answered with resp_err and never touch memory.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed          sign-extend sub-word load data
//   req_addr            byte address
//   req_wdata           store data, right-justified
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            request rejected
//   mem_addr            word-aligned memory address (registered)
//   mem_wdata           word to memory (registered)
//   mem_read/mem_write  memory strobes (registered, mutually exclusive)
//   mem_rdata           combinational read data from memory
module lsu_data_master #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_LIMIT = ADDR_W'(32'h0000_3000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              write_q;
  logic [15:0]       wdata_q;      // only the low half is needed for a merge
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              req_bad;

  // Select the addressed byte/halfword of a little-endian word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/halfword of a word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [15:0] d,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] mask;
    logic [31:0] data;
    if (size == 2'b00) begin
      mask = 32'h0000_00ff << {off, 3'b000};
      data = {24'h0, d[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {off[1], 4'b0000};
      data = {16'h0, d} << {off[1], 4'b0000};
    end
    return (w & ~mask) | (data & mask);
  endfunction

  always_comb begin
    req_bad = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
              (req_addr >= DATA_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        // Accept: latch the request and pick the first access phase.
        S_IDLE: begin
          if (req_valid) begin
            off_q        <= req_addr[1:0];
            size_q       <= req_size;
            signed_q     <= req_signed;
            write_q      <= req_write;
            wdata_q      <= req_wdata[15:0];
            resp_rdata_q <= 32'h0;
            mem_addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_bad) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else if (req_write && req_size == 2'b10) begin
              mem_wdata_q <= req_wdata;
              mem_write_q <= 1'b1;
              state_q     <= S_WR;
            end else begin
              mem_read_q <= 1'b1;
              state_q    <= S_RD;
            end
          end
        end
        // Read phase: mem_rdata is valid this cycle; either finish the load
        // or build the merged word for the write phase.
        S_RD: begin
          mem_read_q <= 1'b0;
          if (write_q) begin
            mem_wdata_q <= store_merge(mem_rdata, wdata_q, off_q, size_q);
            mem_write_q <= 1'b1;
            state_q     <= S_WR;
          end else begin
            resp_rdata_q <= load_extend(mem_rdata, off_q, size_q, signed_q);
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        // Write phase: one cycle of mem_write with address/data already stable.
        S_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        // Response phase: hold everything until the pipeline takes it.
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_lsu_data_master.sv
module tb_lsu_data_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  lsu_data_master #(.ADDR_W(32), .DATA_LIMIT(32'h0000_3000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          quiet = 1'b1;
  bit          bp_hold = 1'b0;
  logic        fill = 1'b1;
  logic [31:0] dmem    [0:4095];
  logic [31:0] ref_mem [0:4095];

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Memory: combinational read, write at the rising edge while mem_write is high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= seed_word(i);
    end else if (mem_write) begin
      dmem[mem_addr[13:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = dmem[mem_addr[13:2]];

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: byte-lane view of the memory, expected strobes and latency.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int          off;
    int          nbytes;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] m;
    off    = int'(a[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.waddr = {a[31:2], 2'b00};
    e.acc = 0; e.rdata = 32'h0; e.err = 1'b0; e.nrd = 0; e.nwr = 0; e.wdata = 32'h0; e.lat = 0;
    if (sz == 2'd3 || (off % nbytes) != 0 || a >= 32'h3000) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!wr) begin
      w = ref_mem[a[13:2]];
      v = w >> (8 * off);
      if (nbytes < 4) begin
        m = (32'd1 << (8 * nbytes)) - 32'd1;
        v = v & m;
        if (sg && v[8 * nbytes - 1]) v = v | ~m;
      end
      e.rdata = v;
      e.lat = 2;
      e.nrd = 1;
    end else begin
      w = ref_mem[a[13:2]];
      for (int k = 0; k < nbytes; k++) w[8 * (off + k) +: 8] = wd[8 * k +: 8];
      ref_mem[a[13:2]] = w;
      e.wdata = w;
      e.nwr = 1;
      e.nrd = (nbytes == 4) ? 0 : 1;
      e.lat = (nbytes == 4) ? 2 : 3;
    end
  endtask

  // Called at a falling edge; returns after the accepting rising edge, at the next falling edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output int acc);
    exp_t e;
    int   n;
    model(wr, sz, sg, a, wd, e);
    sb.push_back(e);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      void'(sb.pop_back());
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc - 1;
    sb[sb.size() - 1].acc = acc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || resp_valid) fail_now("drain_timeout");
  endtask

  // Monitor: strobes and responses are checked against the head of the scoreboard.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_rd = 32'h0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || quiet) begin
      prev_v = 1'b0;
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (mem_read) begin
        rd_cnt++;
        if (sb.size() == 0) fail_now("unexpected_mem_read");
        else check("rd_addr", mem_addr, sb[0].waddr);
      end
      if (mem_write) begin
        wr_cnt++;
        if (sb.size() == 0) fail_now("unexpected_mem_write");
        else begin
          check("wr_addr", mem_addr, sb[0].waddr);
          check("wr_data", mem_wdata, sb[0].wdata);
        end
      end
      if (resp_valid) begin
        check("req_ready_busy", 32'(req_ready), 32'h0);
        if (sb.size() == 0) fail_now("unexpected_resp");
        else begin
          if (!prev_v) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          else if (!prev_rdy) begin
            check("hold_rdata", resp_rdata, prev_rd);
            check("hold_err", 32'(resp_err), 32'(prev_err));
          end
          if (resp_ready) begin
            check("rdata", resp_rdata, sb[0].rdata);
            check("err", 32'(resp_err), 32'(sb[0].err));
            check("n_reads", 32'(rd_cnt), 32'(sb[0].nrd));
            check("n_writes", 32'(wr_cnt), 32'(sb[0].nwr));
            rd_cnt = 0;
            wr_cnt = 0;
            hs_cyc = cyc;
            void'(sb.pop_front());
          end
        end
      end
      prev_v = resp_valid;
      prev_rdy = resp_ready;
      prev_rd = resp_rdata;
      prev_err = resp_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          a2;
    int          n;
    int          r;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    @(negedge clk);
    fill = 1'b0;
    rst_n = 1'b1;
    quiet = 1'b0;
    @(negedge clk);

    // Word, byte and halfword directed cases.
    issue(1'b1, 2'd2, 1'b0, 32'h0100, 32'hDEAD_BEEF, acc);
    issue(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, acc);
    issue(1'b1, 2'd2, 1'b0, 32'h0100, 32'h1122_3344, acc);
    issue(1'b1, 2'd0, 1'b0, 32'h0102, 32'h0000_00AA, acc);
    issue(1'b0, 2'd0, 1'b1, 32'h0102, 32'h0, acc);
    issue(1'b0, 2'd0, 1'b0, 32'h0102, 32'h0, acc);
    issue(1'b1, 2'd2, 1'b0, 32'h0104, 32'h0, acc);
    issue(1'b1, 2'd1, 1'b0, 32'h0106, 32'h0000_8001, acc);
    issue(1'b0, 2'd1, 1'b1, 32'h0106, 32'h0, acc);
    issue(1'b0, 2'd1, 1'b0, 32'h0106, 32'h0, acc);
    // Error cases and the region edge.
    issue(1'b0, 2'd2, 1'b0, 32'h0102, 32'h0, acc);
    issue(1'b1, 2'd1, 1'b0, 32'h0101, 32'h1234_5678, acc);
    issue(1'b0, 2'd3, 1'b0, 32'h0100, 32'h0, acc);
    issue(1'b1, 2'd2, 1'b0, 32'h3000, 32'hCAFE_F00D, acc);
    issue(1'b0, 2'd0, 1'b1, 32'h2FFF, 32'h0, acc);
    issue(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, acc);

    // Backpressure: response held, second request waits for the handshake.
    drain();
    bp_hold = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h0100, 32'h0, acc);
    fork
      begin
        repeat (8) @(posedge clk);
        bp_hold = 1'b0;
      end
    join_none
    issue(1'b0, 2'd0, 1'b1, 32'h0102, 32'h0, a2);
    check("accept_after_handshake", 32'(a2), 32'(hs_cyc + 1));

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 31));
      if (r == 0)      a = 32'h2FFC + 32'($urandom_range(0, 7));
      else if (r == 1) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else             a = 32'h0100 + 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset during the write phase of a byte store.
    quiet = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0108; req_wdata = 32'h0000_005C; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_rd_phase", 32'(mem_read), 32'h1);
    @(negedge clk);
    check("abort_wr_phase", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write_drop", 32'(mem_write), 32'h0);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_abort_resp_valid", 32'(resp_valid), 32'h0);
      check("post_abort_req_ready", 32'(req_ready), 32'h1);
    end
    quiet = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h0108, 32'h0, acc);
    issue(1'b0, 2'd0, 1'b0, 32'h0108, 32'h0, acc);
    drain();

    for (int i = 32'h40; i < 32'h50; i++) check("final_mem", dmem[i], ref_mem[i]);
    check("final_mem_edge", dmem[12'hBFF], ref_mem[12'hBFF]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
